// File: rtl/alu_op_sequencer.sv
// Issues one micro-op at a time to the external 8-bit ALU, with a 4x8 register file and a response handshake.
// Optional ALU_SEQ_OPCNT_EN adds op_count[15:0], a saturating count of successful (non-error) responses.
module alu_op_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [1:0] cmd_ra,
  input  logic [1:0] cmd_rb,
  input  logic [1:0] cmd_rd,
  input  logic [7:0] cmd_imm,
  output logic       alu_m,
  output logic [3:0] alu_s,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_t,
  input  logic       alu_cf,
  input  logic       alu_zf,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_err,
`ifdef ALU_SEQ_OPCNT_EN
  output logic [15:0] op_count,
`endif
  output logic       flag_cf,
  output logic       flag_zf
);

  localparam logic [2:0] OP_PASSA = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_SUB   = 3'd2;
  localparam logic [2:0] OP_AND   = 3'd3;
  localparam logic [2:0] OP_NOTB  = 3'd4;
  localparam logic [2:0] OP_PASSB = 3'd5;
  localparam logic [2:0] OP_ILL   = 3'd6;
  localparam logic [2:0] OP_LDI   = 3'd7;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [2:0] op;
    logic [1:0] rd;
  } cmd_t;

  state_t     state, state_nxt;
  cmd_t       cmd_q;
  logic [7:0] rf [4];
  logic       is_alu;

  // {m, s} for each ALU op; anything else parks the ALU at 0,0000
  function automatic logic [4:0] alu_enc(input logic [2:0] op);
    case (op)
      OP_PASSA: alu_enc = 5'b0_1100;
      OP_ADD:   alu_enc = 5'b1_1001;
      OP_SUB:   alu_enc = 5'b1_0110;
      OP_AND:   alu_enc = 5'b1_1011;
      OP_NOTB:  alu_enc = 5'b1_0101;
      OP_PASSB: alu_enc = 5'b1_1010;
      default:  alu_enc = 5'b0_0000;
    endcase
  endfunction

  assign is_alu    = (cmd_op != OP_ILL) && (cmd_op != OP_LDI);
  assign cmd_ready = (state == IDLE);
  assign res_valid = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = is_alu ? EXEC : RESP;
      EXEC:    state_nxt = RESP;
      RESP:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q    <= '0;
      alu_m    <= 1'b0;
      alu_s    <= 4'd0;
      alu_a    <= 8'd0;
      alu_b    <= 8'd0;
      res_data <= 8'd0;
      res_err  <= 1'b0;
      flag_cf  <= 1'b0;
      flag_zf  <= 1'b0;
      for (int i = 0; i < 4; i++) rf[i] <= 8'd0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          cmd_q.op <= cmd_op;
          cmd_q.rd <= cmd_rd;
          res_err  <= 1'b0;
          if (cmd_op == OP_LDI) begin
            rf[cmd_rd] <= cmd_imm;
            res_data   <= cmd_imm;
          end else if (cmd_op == OP_ILL) begin
            res_data <= 8'd0;
            res_err  <= 1'b1;
          end else begin
            // operands sampled on the accept edge, held stable through EXEC
            {alu_m, alu_s} <= alu_enc(cmd_op);
            alu_a          <= rf[cmd_ra];
            alu_b          <= rf[cmd_rb];
          end
        end
        EXEC: begin
          res_data     <= alu_t;
          rf[cmd_q.rd] <= alu_t;
          if (cmd_q.op == OP_ADD || cmd_q.op == OP_SUB) begin
            flag_cf <= alu_cf;
            flag_zf <= alu_zf;
          end
          alu_m <= 1'b0;
          alu_s <= 4'd0;
          alu_a <= 8'd0;
          alu_b <= 8'd0;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SEQ_OPCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      op_count <= 16'd0;
    else if (res_valid && res_ready && !res_err && op_count != 16'hFFFF)
      op_count <= op_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural model of the external 8-bit ALU.
// Checks op_count as well when built with ALU_SEQ_OPCNT_EN.
module tb_alu_op_sequencer;

  logic       clk, rst_n;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_op;
  logic [1:0] cmd_ra, cmd_rb, cmd_rd;
  logic [7:0] cmd_imm;
  logic       alu_m;
  logic [3:0] alu_s;
  logic [7:0] alu_a, alu_b, alu_t;
  logic       alu_cf, alu_zf;
  logic       res_valid, res_ready;
  logic [7:0] res_data;
  logic       res_err, flag_cf, flag_zf;
`ifdef ALU_SEQ_OPCNT_EN
  logic [15:0] op_count;
`endif

  int vectors = 0;
  int fails   = 0;
  int exp_cnt = 0;
  logic [4:0] ms;

  alu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd), .cmd_imm(cmd_imm),
    .alu_m(alu_m), .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b),
    .alu_t(alu_t), .alu_cf(alu_cf), .alu_zf(alu_zf),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
`ifdef ALU_SEQ_OPCNT_EN
    .op_count(op_count),
`endif
    .flag_cf(flag_cf), .flag_zf(flag_zf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // external ALU: 9-bit result, bit 8 is carry (ADD) or borrow (SUB)
  logic [8:0] r9;
  always_comb begin
    r9 = 9'd0;
    case ({alu_m, alu_s})
      5'b0_1100: r9 = {1'b0, alu_a};
      5'b1_1001: r9 = {1'b0, alu_a} + {1'b0, alu_b};
      5'b1_0110: r9 = {1'b0, alu_b} - {1'b0, alu_a};
      5'b1_1011: r9 = {1'b0, alu_a & alu_b};
      5'b1_0101: r9 = {1'b0, ~alu_b};
      5'b1_1010: r9 = {1'b0, alu_b};
      default:   r9 = 9'd0;
    endcase
  end
  assign alu_t  = r9[7:0];
  assign alu_cf = r9[8];
  assign alu_zf = (r9[7:0] == 8'd0);

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("cmd_ready_timeout", {15'd0, cmd_ready}, 16'd1);
  endtask

  // issue one command at a negedge, return {m,s} seen in the cycle after accept, check the response
  task automatic do_cmd(input string tag, input logic [2:0] op, input logic [1:0] ra, input logic [1:0] rb,
                        input logic [1:0] rd, input logic [7:0] imm, input logic [7:0] exp_data,
                        input logic exp_err, input int exp_lat, output logic [4:0] ms_o);
    int lat;
    wait_ready();
    cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rd = rd; cmd_imm = imm;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    ms_o = {alu_m, alu_s};
    lat = 1;
    while (!res_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 16'(lat), 16'(exp_lat));
    chk({tag, "_data"}, {8'd0, res_data}, {8'd0, exp_data});
    chk({tag, "_err"}, {15'd0, res_err}, {15'd0, exp_err});
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    if (!exp_err) exp_cnt++;
  endtask

  task automatic chk_flags(input string tag, input logic cf, input logic zf);
    chk({tag, "_flags"}, {14'd0, flag_cf, flag_zf}, {14'd0, cf, zf});
  endtask

  task automatic chk_cnt(input string tag);
`ifdef ALU_SEQ_OPCNT_EN
    chk({tag, "_opcnt"}, op_count, 16'(exp_cnt));
`else
    if (tag.len() == 0) $display("tag empty");
`endif
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_ra = '0; cmd_rb = '0;
    cmd_rd = '0; cmd_imm = '0; res_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", {15'd0, cmd_ready}, 16'd1);
    chk("rst_valid", {15'd0, res_valid}, 16'd0);
    chk("rst_alu", {3'd0, alu_m, alu_s, alu_a}, 16'd0);
    chk("rst_res", {7'd0, res_err, res_data}, 16'd0);
    chk_flags("rst", 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: ADD with carry out and zero result
    do_cmd("ldi_r0", 3'd7, 2'd0, 2'd0, 2'd0, 8'h80, 8'h80, 1'b0, 1, ms);
    do_cmd("ldi_r1", 3'd7, 2'd0, 2'd0, 2'd1, 8'h80, 8'h80, 1'b0, 1, ms);
    do_cmd("add", 3'd1, 2'd0, 2'd1, 2'd2, 8'h00, 8'h00, 1'b0, 2, ms);
    chk("add_ms", {11'd0, ms}, 16'b1_1001);
    chk_flags("add", 1'b1, 1'b1);
    chk("park_after", {3'd0, alu_m, alu_s, alu_a}, 16'd0);
    do_cmd("passb_r2", 3'd5, 2'd0, 2'd2, 2'd3, 8'h00, 8'h00, 1'b0, 2, ms);
    chk("passb_ms", {11'd0, ms}, 16'b1_1010);
    chk_flags("passb", 1'b1, 1'b1);

    // 2: SUB is b-a with borrow, AND holds flags
    do_cmd("ldi_r0b", 3'd7, 2'd0, 2'd0, 2'd0, 8'h05, 8'h05, 1'b0, 1, ms);
    do_cmd("ldi_r1b", 3'd7, 2'd0, 2'd0, 2'd1, 8'h03, 8'h03, 1'b0, 1, ms);
    do_cmd("sub", 3'd2, 2'd0, 2'd1, 2'd3, 8'h00, 8'hFE, 1'b0, 2, ms);
    chk("sub_ms", {11'd0, ms}, 16'b1_0110);
    chk_flags("sub", 1'b1, 1'b0);
    do_cmd("and", 3'd3, 2'd0, 2'd1, 2'd2, 8'h00, 8'h01, 1'b0, 2, ms);
    chk_flags("and", 1'b1, 1'b0);

    // 3: NOTB then PASSA of its result
    do_cmd("ldi_r1c", 3'd7, 2'd0, 2'd0, 2'd1, 8'h3C, 8'h3C, 1'b0, 1, ms);
    do_cmd("notb", 3'd4, 2'd0, 2'd1, 2'd0, 8'h00, 8'hC3, 1'b0, 2, ms);
    do_cmd("passa", 3'd0, 2'd0, 2'd0, 2'd2, 8'h00, 8'hC3, 1'b0, 2, ms);
    chk("passa_ms", {11'd0, ms}, 16'b0_1100);
    chk_cnt("mid");

    // 4: response back-pressure with a queued command
    wait_ready();
    cmd_op = 3'd7; cmd_rd = 2'd3; cmd_imm = 8'h5A; cmd_valid = 1'b1;
    @(negedge clk);
    chk("stall_v0", {15'd0, res_valid}, 16'd1);
    chk("stall_d0", {8'd0, res_data}, 16'h5A);
    cmd_imm = 8'h11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", {15'd0, res_valid}, 16'd1);
      chk("stall_data", {8'd0, res_data}, 16'h5A);
      chk("stall_ready", {15'd0, cmd_ready}, 16'd0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    exp_cnt++;
    chk("nobypass_valid", {15'd0, res_valid}, 16'd0);
    chk("ready_again", {15'd0, cmd_ready}, 16'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("queued_valid", {15'd0, res_valid}, 16'd1);
    chk("queued_data", {8'd0, res_data}, 16'h11);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    exp_cnt++;
    do_cmd("raw_r3", 3'd0, 2'd3, 2'd0, 2'd3, 8'h00, 8'h11, 1'b0, 2, ms);

    // 5: illegal op leaves regfile, flags and counter alone
    do_cmd("illegal", 3'd6, 2'd0, 2'd0, 2'd0, 8'hAA, 8'h00, 1'b1, 1, ms);
    chk_flags("illegal", 1'b1, 1'b0);
    chk_cnt("illegal");
    do_cmd("ill_r0", 3'd0, 2'd0, 2'd0, 2'd1, 8'h00, 8'hC3, 1'b0, 2, ms);
    chk_cnt("after_ill");

    // 6: reset while the ADD is in EXEC
    do_cmd("ldi_r0d", 3'd7, 2'd0, 2'd0, 2'd0, 8'hFF, 8'hFF, 1'b0, 1, ms);
    do_cmd("ldi_r1d", 3'd7, 2'd0, 2'd0, 2'd1, 8'h01, 8'h01, 1'b0, 1, ms);
    wait_ready();
    cmd_op = 3'd1; cmd_ra = 2'd0; cmd_rb = 2'd1; cmd_rd = 2'd2; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("exec_ops", {alu_a, alu_b}, 16'hFF01);
    chk("exec_ms", {11'd0, alu_m, alu_s}, 16'b1_1001);
    rst_n = 1'b0;
    #1;
    chk("arst_ready", {15'd0, cmd_ready}, 16'd1);
    chk("arst_valid", {15'd0, res_valid}, 16'd0);
    chk("arst_alu", {alu_a, alu_b}, 16'd0);
    chk("arst_ms", {11'd0, alu_m, alu_s}, 16'd0);
    chk_flags("arst", 1'b0, 1'b0);
    exp_cnt = 0;
    chk_cnt("arst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_cmd("post_r0", 3'd0, 2'd0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 2, ms);
    do_cmd("post_r1", 3'd5, 2'd0, 2'd1, 2'd3, 8'h00, 8'h00, 1'b0, 2, ms);
    do_cmd("post_r2", 3'd0, 2'd2, 2'd0, 2'd3, 8'h00, 8'h00, 1'b0, 2, ms);
    chk_flags("post", 1'b0, 1'b0);
    chk_cnt("post");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
